// File: rtl/hack_data_memory_if.sv
// CPU/keyboard/display bus of the Hack data memory.
// Bus-error reporting signals exist only when HACK_DMEM_BUSERR_EN is defined.
interface hack_data_memory_if;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        disp_en;
  logic [12:0] disp_addr;
  logic [15:0] disp_data;
`ifdef HACK_DMEM_BUSERR_EN
  logic        bus_err;
  logic [15:0] err_addr;
  logic        err_clr;
`endif

  modport master (
    output addressM, outM, writeM, kbd_valid, kbd_code, disp_en, disp_addr,
    input  inM, disp_data
`ifdef HACK_DMEM_BUSERR_EN
    , output err_clr, input bus_err, err_addr
`endif
  );

  modport slave (
    input  addressM, outM, writeM, kbd_valid, kbd_code, disp_en, disp_addr,
    output inM, disp_data
`ifdef HACK_DMEM_BUSERR_EN
    , input err_clr, output bus_err, err_addr
`endif
  );
endinterface

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen buffer with registered display port, keyboard register.
// Optional sticky bus-error capture of illegal writes under HACK_DMEM_BUSERR_EN.
module hack_data_memory #(
  parameter int          RAM_WORDS    = 16384,
  parameter int          SCREEN_WORDS = 8192,
  parameter logic [15:0] KBD_ADDR     = 16'h6000
) (
  input logic               clk,
  input logic               reset,
  hack_data_memory_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCREEN_WORDS];
  logic [15:0] r_kbd;
  logic [15:0] r_disp;
  logic [1:0]  r_rst_q;

  logic [14:0] w_a;
  logic        w_is_ram, w_is_scr, w_is_kbd, w_run, w_we;
  logic [15:0] w_in;

  assign w_a      = bus.addressM[14:0];
  assign w_is_ram = ~w_a[14];
  assign w_is_scr = (w_a[14:13] == 2'b10);
  assign w_is_kbd = (w_a == KBD_ADDR[14:0]);

  // Release chain: updates open at the second edge after reset rises,
  // and close immediately (asynchronously) when reset falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_q <= '0;
    else        r_rst_q <= {r_rst_q[0], 1'b1};
  end

  assign w_run = reset & (|r_rst_q);
  assign w_we  = w_run & bus.writeM;

  always_comb begin
    w_in = '0;
    if (w_is_ram)      w_in = r_ram[w_a[RAM_AW-1:0]];
    else if (w_is_scr) w_in = r_scr[w_a[SCR_AW-1:0]];
    else if (w_is_kbd) w_in = r_kbd;
  end
  assign bus.inM = w_in;

  // Memory contents survive reset; only the write enable is gated.
  always_ff @(posedge clk) begin
    if (w_we && w_is_ram) r_ram[w_a[RAM_AW-1:0]] <= bus.outM;
    if (w_we && w_is_scr) r_scr[w_a[SCR_AW-1:0]] <= bus.outM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_kbd <= '0;
    else if (w_run && bus.kbd_valid) r_kbd <= bus.kbd_code;
  end

  // Nonblocking read of r_scr yields the pre-write word on a same-edge CPU write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_disp <= '0;
    else if (bus.disp_en) r_disp <= r_scr[bus.disp_addr];
  end
  assign bus.disp_data = r_disp;

`ifdef HACK_DMEM_BUSERR_EN
  logic        r_bus_err;
  logic [15:0] r_err_addr;
  logic        w_bad;

  assign w_bad = w_we & ~w_is_ram & ~w_is_scr;

  // A new error beats a simultaneous clear; the first error address sticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else if (w_bad) begin
      r_bus_err <= 1'b1;
      if (!r_bus_err || bus.err_clr) r_err_addr <= bus.addressM;
    end else if (bus.err_clr) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end
  end
  assign bus.bus_err  = r_bus_err;
  assign bus.err_addr = r_err_addr;
`endif
endmodule

// File: tb/tb_hack_data_memory.sv
// Randomized and directed bench for hack_data_memory against an array-based reference model.
module tb_hack_data_memory;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hack_data_memory_if ifc ();
  hack_data_memory dut (.clk(clk), .reset(reset), .bus(ifc));

  int n_chk = 0, n_fail = 0;

  // reference model
  logic [15:0] m_ram [16384];
  bit          m_ramk [16384];
  logic [15:0] m_scr [8192];
  bit          m_scrk [8192];
  logic [15:0] m_kbd, m_disp;
  bit          m_dispk;
  int          m_rel;
  bit          m_err;
  logic [15:0] m_eaddr;

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    m_kbd = 0; m_disp = 0; m_dispk = 1; m_rel = 0; m_err = 0; m_eaddr = 0;
  endtask

  function automatic void exp_read(input logic [15:0] ad, output logic [15:0] v, output bit k);
    logic [14:0] a = ad[14:0];
    k = 1; v = 0;
    if (a < 15'h4000)       begin v = m_ram[a[13:0]]; k = m_ramk[a[13:0]]; end
    else if (a < 15'h6000)  begin v = m_scr[a - 15'h4000]; k = m_scrk[a - 15'h4000]; end
    else if (a == 15'h6000) v = m_kbd;
  endfunction

  task automatic model_edge();
    logic [14:0] a = ifc.addressM[14:0];
    bit acc = reset && (m_rel >= 1);
    bit bad = acc && ifc.writeM && (a >= 15'h6000);
    if (!reset) begin model_rst(); return; end
    m_rel++;
    if (ifc.disp_en) begin m_disp = m_scr[ifc.disp_addr]; m_dispk = m_scrk[ifc.disp_addr]; end
    if (acc && ifc.writeM) begin
      if (a < 15'h4000)      begin m_ram[a[13:0]] = ifc.outM; m_ramk[a[13:0]] = 1; end
      else if (a < 15'h6000) begin m_scr[a - 15'h4000] = ifc.outM; m_scrk[a - 15'h4000] = 1; end
    end
    if (acc && ifc.kbd_valid) m_kbd = ifc.kbd_code;
`ifdef HACK_DMEM_BUSERR_EN
    if (bad) begin
      if (!m_err || ifc.err_clr) m_eaddr = ifc.addressM;
      m_err = 1;
    end else if (ifc.err_clr) begin m_err = 0; m_eaddr = 0; end
`else
    if (bad) m_eaddr = ifc.addressM;
`endif
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [15:0] v; bit k;
    #1;
    exp_read(ifc.addressM, v, k);
    if (k)       check("inM", ifc.inM, v);
    if (m_dispk) check("disp_data", ifc.disp_data, m_disp);
`ifdef HACK_DMEM_BUSERR_EN
    check("bus_err", {15'd0, ifc.bus_err}, {15'd0, m_err});
    check("err_addr", ifc.err_addr, m_eaddr);
`endif
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drv(input logic [15:0] ad, input logic [15:0] d, input logic we);
    ifc.addressM = ad; ifc.outM = d; ifc.writeM = we;
    ifc.kbd_valid = 0; ifc.disp_en = 0;
`ifdef HACK_DMEM_BUSERR_EN
    ifc.err_clr = 0;
`endif
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 9))
      0, 1:    return 16'($urandom_range(0, 15));
      2:       return 16'($urandom_range(16368, 16383));
      3:       return 16'h8000 | 16'($urandom_range(0, 15));
      4, 5:    return 16'h4000 + 16'($urandom_range(0, 15));
      6:       return 16'h5FF0 + 16'($urandom_range(0, 15));
      7:       return 16'h6000;
      default: return 16'($urandom_range(16'h6001, 16'h7FFF));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) m_ramk[i] = 0;
    for (int i = 0; i < 8192; i++)  m_scrk[i] = 0;
    model_rst();
    drv(0, 0, 0); ifc.kbd_code = 0; ifc.disp_addr = 0;
    @(negedge clk);
    step(); step();
    #2 reset = 1;
    step();

    // RAM write / read-after-write
    drv(1003, 1, 1); step();
    drv(1003, 11111, 1); #1 check("raw_old", ifc.inM, 16'd1); step();
    drv(1003, 0, 0); #1 check("raw_new", ifc.inM, 16'd11111); step();
    drv(1004, 11110, 1); step();
    drv(1004, 0, 0); #1 check("ram1004", ifc.inM, 16'd11110); step();
    drv(1003, 0, 0); #1 check("ram1003", ifc.inM, 16'd11111); step();

    // screen and display port
    drv(16'h4010, 16'hA5A5, 1); step();
    drv(0, 0, 0); ifc.disp_en = 1; ifc.disp_addr = 13'h10; step();
    drv(16'h4010, 16'h1234, 1); #1 check("disp_rd", ifc.disp_data, 16'hA5A5);
    ifc.disp_en = 1; ifc.disp_addr = 13'h10; step();
    drv(0, 0, 0); ifc.disp_en = 1; ifc.disp_addr = 13'h10;
    #1 check("disp_rbw", ifc.disp_data, 16'hA5A5); step();
    drv(0, 0, 0); #1 check("disp_new", ifc.disp_data, 16'h1234); step();
    drv(0, 0, 0); #1 check("disp_hold", ifc.disp_data, 16'h1234); step();

    // keyboard
    drv(16'h6000, 0, 0); ifc.kbd_valid = 1; ifc.kbd_code = 75; step();
    drv(16'h6000, 0, 0); #1 check("kbd75", ifc.inM, 16'd75); step();
    drv(16'h6000, 9, 1); step();
    drv(16'h6000, 0, 0); #1 check("kbd_ro", ifc.inM, 16'd75); ifc.kbd_valid = 1; ifc.kbd_code = 0; step();
    drv(16'h6000, 0, 0); #1 check("kbd_rel", ifc.inM, 16'd0); step();

    // unmapped
    drv(16'h6005, 16'h7777, 1); step();
    drv(16'h6005, 0, 0); #1 check("unmapped", ifc.inM, 16'd0);
`ifdef HACK_DMEM_BUSERR_EN
    check("err_set", {15'd0, ifc.bus_err}, 16'd1);
    check("err_addr1", ifc.err_addr, 16'h6005);
`endif
    step();
    drv(16'h7000, 1, 1); step();
    drv(0, 0, 0);
`ifdef HACK_DMEM_BUSERR_EN
    #1 check("err_first", ifc.err_addr, 16'h6005);
    ifc.err_clr = 1;
`endif
    step();
    drv(0, 0, 0);
`ifdef HACK_DMEM_BUSERR_EN
    #1 check("err_clr", {15'd0, ifc.bus_err}, 16'd0);
    check("err_clr_a", ifc.err_addr, 16'd0);
`endif
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drv(rnd_addr(), 16'($urandom), 1'($urandom_range(0, 1)));
      ifc.kbd_valid = ($urandom_range(0, 4) == 0);
      ifc.kbd_code  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      ifc.disp_en   = 1'($urandom_range(0, 1));
      ifc.disp_addr = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 15)) : 13'h1FF0 + 13'($urandom_range(0, 15));
`ifdef HACK_DMEM_BUSERR_EN
      ifc.err_clr   = ($urandom_range(0, 19) == 0);
`endif
      step();
    end

    // reset mid-write, then the two-edge release
    drv(5, 555, 1); step();
    drv(6, 66, 1); step();
    drv(7, 77, 1); step();
    drv(16'h6000, 0, 0); ifc.kbd_valid = 1; ifc.kbd_code = 16'h00AB;
    ifc.disp_en = 1; ifc.disp_addr = 13'h10; step();
    drv(5, 42, 1);
    #2 reset = 0; model_rst();
    step();
    drv(5, 0, 0); #1 check("rst_ram5", ifc.inM, 16'd555);
    check("rst_disp", ifc.disp_data, 16'd0); step();
    drv(16'h6000, 0, 0); #1 check("rst_kbd", ifc.inM, 16'd0); step();
    drv(6, 100, 1);
    #2 reset = 1;
    step();
    drv(7, 200, 1); step();
    drv(6, 0, 0); #1 check("rel_drop", ifc.inM, 16'd66); step();
    drv(7, 0, 0); #1 check("rel_land", ifc.inM, 16'd200); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory stage directly downstream of the Hack CPU. It consumes the CPU's outM, writeM and addressM, and returns inM in the same cycle.
- Memory map: 16K-word RAM, 8K-word screen buffer with a second registered read port for the display scanner, and a read-only keyboard register loaded by a strobe handshake.
- Sits between CPU and the video/keyboard front-ends in the top-level computer.

Parameters:
RAM_WORDS, 16384, RAM depth; occupies addresses 0x0000-0x3FFF
SCREEN_WORDS, 8192, screen buffer depth; occupies 0x4000-0x5FFF
KBD_ADDR, 16'h6000, keyboard register address

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
addressM  input  16  CPU data address (bit 15 ignored for decode)
outM  input  16  CPU write data
writeM  input  1  CPU write enable, sampled on rising clk
inM  output  16  read data for addressM, combinational
kbd_valid  input  1  keyboard strobe; one-cycle pulse
kbd_code  input  16  key code captured on kbd_valid; 0 = no key pressed
disp_en  input  1  display read request
disp_addr  input  13  screen word index
disp_data  output  16  screen word, registered

Behaviour:
- Decode uses addressM[14:0]:
  - 0x0000-0x3FFF: RAM[addr[13:0]].
  - 0x4000-0x5FFF: SCREEN[addr[12:0]].
  - 0x6000: KBD register.
  - 0x6001-0x7FFF: unmapped; reads return 0, writes are ignored.
- inM is combinational from addressM and current contents, with zero latency, so the CPU's D=M and AD=D-M complete in one cycle.
- Write: on rising clk with writeM=1, outM is stored at the decoded RAM or screen location. Writes to KBD or unmapped addresses are ignored.
- Read-after-write: in the write cycle, inM shows the old value; from the next cycle on, it shows the new value.
- Keyboard:
  - kbd_valid=1 at a rising edge loads kbd_reg <= kbd_code.
  - Otherwise kbd_reg holds.
  - kbd_code=0 with kbd_valid models key release.
- Display port:
  - With disp_en=1 at edge N, disp_data = SCREEN[disp_addr] valid after edge N (1-cycle latency).
  - With disp_en=0, disp_data holds.
  - If the CPU writes the same screen word at edge N, disp_data returns the pre-write value (read-before-write).
- Reset (reset=0), asynchronous:
  - kbd_reg=0, disp_data=0.
  - RAM and screen contents are NOT cleared.
  - Writes and kbd loads are blocked while reset is low.
  - Release is synchronised internally through a 2-flop deassertion chain. The first write is accepted at the second rising edge after reset rises.
- Reset asserted mid-write: the write in that cycle is discarded. No partial update is permitted.
- Arithmetic: none. All data paths are 16 bits, unsigned, with no width conversion.

Optional Feature:
HACK_DMEM_BUSERR_EN
- Defined:
  - Adds output ports bus_err (1 bit, sticky) and err_addr (16 bits) and input port err_clr (1 bit).
  - A writeM=1 cycle to KBD_ADDR or an unmapped address sets bus_err at that edge.
  - err_addr captures that addressM only if bus_err was previously 0 (first error wins).
  - err_clr=1 at an edge clears bus_err and err_addr to 0. If err_clr and a new error occur at the same edge, the error wins.
  - Reset clears both.
- Undefined: these ports and their logic are absent. Illegal writes are silently ignored, with identical memory behaviour.

Test Plan:
- RAM write/read: addressM=1003, outM=11111, writeM=1 for one edge, then writeM=0 -> inM=11111 from the next cycle; inM showed old value during the write cycle.
- MD=D-1 sequence: write 11110 to 1004, then read 1004 -> 11110; RAM[1003] is still 11111.
- Screen/display: CPU writes 0xA5A5 to 0x4010; disp_en=1, disp_addr=0x0010 at the following edge -> disp_data=0xA5A5 one cycle later. Same-edge write of 0x1234 returns 0xA5A5, and the next request returns 0x1234.
- Keyboard: kbd_valid pulse with kbd_code=75 -> inM at 0x6000 = 75. A CPU write of 9 to 0x6000 leaves 75. A pulse with kbd_code=0 -> 0.
- Unmapped: write 0x7777 to 0x6005 -> inM at 0x6005 = 0. With HACK_DMEM_BUSERR_EN: bus_err=1, err_addr=0x6005. A second bad write to 0x7000 keeps err_addr=0x6005. err_clr -> both 0.
- Reset: assert reset=0 mid-write of 42 to address 5 -> RAM[5] is unchanged, kbd_reg=0, disp_data=0. After release, a write at the first edge is dropped and a write at the second edge lands.
